// File: rtl/enigma_key_sequencer_if.sv
// Keystroke, datapath and ciphertext handshake bundle for the Enigma key sequencer.
// The slave side is the sequencer. The master side is the keyboard, datapath and consumer.
interface enigma_key_sequencer_if;
  logic       key_valid;
  logic [7:0] key_char;
  logic       key_ready;
  logic       dp_start;
  logic [4:0] dp_in;
  logic       dp_done;
  logic [4:0] dp_out;
  logic       out_valid;
  logic [7:0] out_char;
  logic       out_ready;

  modport slave (
    input  key_valid, key_char, dp_done, dp_out, out_ready,
    output key_ready, dp_start, dp_in, out_valid, out_char
  );

  modport master (
    output key_valid, key_char, dp_done, dp_out, out_ready,
    input  key_ready, dp_start, dp_in, out_valid, out_char
  );
endinterface

// File: rtl/enigma_key_sequencer.sv
// Enigma control FSM. It validates a keystroke, double-steps the rotors, runs one datapath
// encipherment with a timeout, and hands the ciphertext letter to the consumer.
module enigma_key_sequencer #(
  parameter int NOTCH_R = 16,
  parameter int NOTCH_M = 4,
  parameter int TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  enigma_key_sequencer_if.slave bus,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_pos_l,
  input  logic [4:0]            cfg_pos_m,
  input  logic [4:0]            cfg_pos_r,
  output logic [4:0]            pos_l,
  output logic [4:0]            pos_m,
  output logic [4:0]            pos_r,
  output logic                  error_flag,
  output logic [1:0]            err_code
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [1:0] ERR_KEY  = 2'd1;
  localparam logic [1:0] ERR_SELF = 2'd2;
  localparam logic [1:0] ERR_TIME = 2'd3;

  typedef enum logic [2:0] {IDLE, STEP, START, WAIT, OUT} state_t;

  state_t           state_reg, state_next;
  logic [4:0]       pos_l_reg, pos_l_next;
  logic [4:0]       pos_m_reg, pos_m_next;
  logic [4:0]       pos_r_reg, pos_r_next;
  logic [4:0]       idx_reg, idx_next;
  logic [7:0]       out_char_reg, out_char_next;
  logic             err_flag_reg, err_flag_next;
  logic [1:0]       err_code_reg, err_code_next;
  logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

  logic [4:0] cfg_raw [3];
  logic [4:0] cfg_mod [3];
  logic       key_upper, key_lower;

  function automatic logic [4:0] inc26(input logic [4:0] v);
    return (v == 5'd25) ? 5'd0 : v + 5'd1;
  endfunction

  assign cfg_raw[0] = cfg_pos_l;
  assign cfg_raw[1] = cfg_pos_m;
  assign cfg_raw[2] = cfg_pos_r;

  // Config values 26..31 fold back into range with a single subtraction.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cfg_mod
      assign cfg_mod[gi] = (cfg_raw[gi] > 5'd25) ? cfg_raw[gi] - 5'd26 : cfg_raw[gi];
    end
  endgenerate

  assign key_upper = (bus.key_char >= 8'd65) && (bus.key_char <= 8'd90);
  assign key_lower = (bus.key_char >= 8'd97) && (bus.key_char <= 8'd122);

  always_comb begin
    state_next    = state_reg;
    pos_l_next    = pos_l_reg;
    pos_m_next    = pos_m_reg;
    pos_r_next    = pos_r_reg;
    idx_next      = idx_reg;
    out_char_next = out_char_reg;
    err_flag_next = 1'b0;
    err_code_next = err_code_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        if (bus.key_valid) begin
          if (key_upper) begin
            idx_next   = 5'(bus.key_char - 8'd65);
            state_next = STEP;
          end else if (key_lower) begin
            idx_next   = 5'(bus.key_char - 8'd97);
            state_next = STEP;
          end else begin
            err_flag_next = 1'b1;
            err_code_next = ERR_KEY;
          end
        end else if (cfg_we) begin
          pos_l_next = cfg_mod[0];
          pos_m_next = cfg_mod[1];
          pos_r_next = cfg_mod[2];
        end
      end
      STEP: begin
        // The middle rotor's own notch moves both itself and the left rotor (double step).
        pos_r_next = inc26(pos_r_reg);
        if ((pos_r_reg == 5'(NOTCH_R)) || (pos_m_reg == 5'(NOTCH_M)))
          pos_m_next = inc26(pos_m_reg);
        if (pos_m_reg == 5'(NOTCH_M))
          pos_l_next = inc26(pos_l_reg);
        state_next = START;
      end
      START: begin
        wait_cnt_next = '0;
        state_next    = WAIT;
      end
      WAIT: begin
        if (bus.dp_done) begin
          if ((bus.dp_out == idx_reg) || (bus.dp_out > 5'd25)) begin
            err_flag_next = 1'b1;
            err_code_next = ERR_SELF;
            state_next    = IDLE;
          end else begin
            out_char_next = {3'b000, bus.dp_out} + 8'd65;
            state_next    = OUT;
          end
        end else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
          err_flag_next = 1'b1;
          err_code_next = ERR_TIME;
          state_next    = IDLE;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      OUT: begin
        if (bus.out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= IDLE;
      pos_l_reg    <= 5'd0;
      pos_m_reg    <= 5'd0;
      pos_r_reg    <= 5'd0;
      idx_reg      <= 5'd0;
      out_char_reg <= 8'd65;
      err_flag_reg <= 1'b0;
      err_code_reg <= 2'd0;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      pos_l_reg    <= pos_l_next;
      pos_m_reg    <= pos_m_next;
      pos_r_reg    <= pos_r_next;
      idx_reg      <= idx_next;
      out_char_reg <= out_char_next;
      err_flag_reg <= err_flag_next;
      err_code_reg <= err_code_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  assign bus.key_ready = (state_reg == IDLE);
  assign bus.dp_start  = (state_reg == START);
  assign bus.out_valid = (state_reg == OUT);
  assign bus.dp_in     = idx_reg;
  assign bus.out_char  = out_char_reg;
  assign pos_l         = pos_l_reg;
  assign pos_m         = pos_m_reg;
  assign pos_r         = pos_r_reg;
  assign error_flag    = err_flag_reg;
  assign err_code      = err_code_reg;
endmodule

// File: tb/tb_enigma_key_sequencer.sv
// Bench for enigma_key_sequencer: directed test-plan steps followed by random keystrokes.
// Every result is checked against a rotor/error reference model.
module tb_enigma_key_sequencer;
  localparam int NOTCH_R = 16;
  localparam int NOTCH_M = 4;
  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [4:0] cfg_pos_l = '0, cfg_pos_m = '0, cfg_pos_r = '0;
  logic [4:0] pos_l, pos_m, pos_r;
  logic       error_flag;
  logic [1:0] err_code;

  enigma_key_sequencer_if bus ();

  enigma_key_sequencer #(.NOTCH_R(NOTCH_R), .NOTCH_M(NOTCH_M), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cfg_we(cfg_we), .cfg_pos_l(cfg_pos_l), .cfg_pos_m(cfg_pos_m), .cfg_pos_r(cfg_pos_r),
    .pos_l(pos_l), .pos_m(pos_m), .pos_r(pos_r),
    .error_flag(error_flag), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  // Reference model: rotor positions and last error code.
  int m_l = 0, m_m = 0, m_r = 0, m_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_letter(input int c);
    return (c >= 65 && c <= 90) || (c >= 97 && c <= 122);
  endfunction

  function automatic int letter_idx(input int c);
    return (c <= 90) ? c - 65 : c - 97;
  endfunction

  task automatic model_step();
    bit mid_turn, right_turn;
    mid_turn   = (m_m == NOTCH_M);
    right_turn = (m_r == NOTCH_R);
    if (mid_turn) m_l = (m_l + 1) % 26;
    if (mid_turn || right_turn) m_m = (m_m + 1) % 26;
    m_r = (m_r + 1) % 26;
  endtask

  task automatic chk_pos(input string tag);
    chk(tag, {17'd0, pos_l, pos_m, pos_r}, {17'd0, 5'(m_l), 5'(m_m), 5'(m_r)});
  endtask

  task automatic load_cfg(input int l, input int m, input int r);
    cfg_we = 1'b1;
    cfg_pos_l = 5'(l); cfg_pos_m = 5'(m); cfg_pos_r = 5'(r);
    @(negedge clk);
    cfg_we = 1'b0;
    m_l = l % 26; m_m = m % 26; m_r = r % 26;
    chk_pos("cfg_load");
  endtask

  // Called at a negedge with the DUT idle. lat = WAIT cycle index at which dp_done is
  // driven (>= TIMEOUT means never); stall = cycles out_ready stays low in OUT.
  task automatic run_key(input logic [7:0] ch, input int lat, input logic [4:0] res,
                         input int stall, input bit with_cfg);
    int idx;
    bit got_done;
    logic [7:0] held;
    chk("idle_key_ready", bus.key_ready, 1);
    chk("idle_err_code", err_code, m_err);
    bus.key_valid = 1'b1;
    bus.key_char  = ch;
    if (with_cfg) begin
      cfg_we = 1'b1;
      cfg_pos_l = 5'($urandom_range(0, 31));
      cfg_pos_m = 5'($urandom_range(0, 31));
      cfg_pos_r = 5'($urandom_range(0, 31));
    end
    @(negedge clk);
    bus.key_valid = 1'b0;
    cfg_we = 1'b0;
    if (!is_letter(int'(ch))) begin
      m_err = 1;
      chk("badkey_flag", error_flag, 1);
      chk("badkey_code", err_code, 1);
      chk("badkey_ready", bus.key_ready, 1);
      chk("badkey_nostart", bus.dp_start, 0);
      chk_pos("badkey_pos");
      @(negedge clk);
      chk("badkey_pulse_end", error_flag, 0);
      return;
    end
    idx = letter_idx(int'(ch));
    model_step();
    chk("step_ready_low", bus.key_ready, 0);
    chk("step_no_start", bus.dp_start, 0);
    @(negedge clk);
    chk("start_pulse", bus.dp_start, 1);
    chk("start_dp_in", bus.dp_in, idx);
    chk_pos("start_pos");
    @(negedge clk);
    chk("start_single", bus.dp_start, 0);
    got_done = 1'b0;
    for (int w = 0; w < TIMEOUT; w++) begin
      if (w == lat) begin
        bus.dp_done = 1'b1;
        bus.dp_out  = res;
        got_done    = 1'b1;
      end
      @(negedge clk);
      bus.dp_done = 1'b0;
      if (got_done) break;
      if (w < TIMEOUT - 1) begin
        if (bus.out_valid !== 1'b0 || error_flag !== 1'b0 || bus.dp_start !== 1'b0)
          chk("wait_quiet", {bus.out_valid, error_flag, bus.dp_start}, 0);
      end
    end
    if (!got_done) begin
      m_err = 3;
      chk("timeout_flag", error_flag, 1);
      chk("timeout_code", err_code, 3);
      chk("timeout_ready", bus.key_ready, 1);
      chk_pos("timeout_pos");
      @(negedge clk);
      chk("timeout_pulse_end", error_flag, 0);
    end else if (int'(res) == idx || res > 5'd25) begin
      m_err = 2;
      chk("self_flag", error_flag, 1);
      chk("self_code", err_code, 2);
      chk("self_no_out", bus.out_valid, 0);
      chk("self_ready", bus.key_ready, 1);
      chk_pos("self_pos");
      @(negedge clk);
      chk("self_pulse_end", error_flag, 0);
    end else begin
      chk("out_valid", bus.out_valid, 1);
      chk("out_char", bus.out_char, int'(res) + 65);
      chk("out_no_err", error_flag, 0);
      held = bus.out_char;
      for (int s = 0; s < stall; s++) begin
        cfg_we = 1'b1;
        cfg_pos_l = 5'($urandom_range(0, 31));
        cfg_pos_m = 5'($urandom_range(0, 31));
        cfg_pos_r = 5'($urandom_range(0, 31));
        @(negedge clk);
        cfg_we = 1'b0;
        if (bus.out_valid !== 1'b1 || bus.out_char !== held || error_flag !== 1'b0)
          chk("stall_hold", {bus.out_valid, bus.out_char, error_flag}, {1'b1, held, 1'b0});
        if (pos_l !== 5'(m_l) || pos_m !== 5'(m_m) || pos_r !== 5'(m_r))
          chk_pos("stall_pos");
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      chk("out_done", bus.out_valid, 0);
      chk("out_back_idle", bus.key_ready, 1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] ch;
    int lat;
    logic [4:0] res;
    bus.key_valid = 1'b0; bus.key_char = 8'd0;
    bus.dp_done = 1'b0;   bus.dp_out = 5'd0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_pos", {pos_l, pos_m, pos_r}, 0);
    chk("rst_dp_in", bus.dp_in, 0);
    chk("rst_out_char", bus.out_char, 65);
    chk("rst_strobes", {bus.dp_start, bus.out_valid, error_flag}, 0);
    chk("rst_err_code", err_code, 0);
    chk("rst_key_ready", bus.key_ready, 1);

    // 'A' with datapath result 1 at the earliest cycle, held 3 cycles.
    run_key(8'd65, 0, 5'd1, 3, 1'b0);
    chk("A_pos", {pos_l, pos_m, pos_r}, {5'd0, 5'd0, 5'd1});

    // Right-notch turnover, then double step.
    load_cfg(0, 3, 16);
    run_key(8'd72, 2, 5'd9, 0, 1'b0);
    chk("turn_pos", {pos_l, pos_m, pos_r}, {5'd0, 5'd4, 5'd17});
    run_key(8'd73, 1, 5'd10, 0, 1'b0);
    chk("dbl_pos", {pos_l, pos_m, pos_r}, {5'd1, 5'd5, 5'd18});

    // Right-rotor wrap from 'z', out-of-range cfg values.
    load_cfg(0, 0, 25);
    run_key(8'd122, 0, 5'd3, 0, 1'b0);
    chk("wrap_pos", {pos_l, pos_m, pos_r}, 0);
    load_cfg(31, 26, 29);
    chk("cfg_mod_pos", {pos_l, pos_m, pos_r}, {5'd5, 5'd0, 5'd3});

    run_key(8'd64, 0, 5'd0, 0, 1'b0);              // invalid '@'
    run_key(8'd91, 0, 5'd0, 0, 1'b1);              // invalid '[' with cfg_we: key wins
    run_key(8'd67, 0, 5'd2, 0, 1'b0);              // self-encipher
    run_key(8'd68, 99, 5'd0, 0, 1'b0);             // timeout
    run_key(8'd69, 3, 5'd30, 0, 1'b0);             // out-of-range result
    run_key(8'd70, TIMEOUT - 1, 5'd7, 0, 1'b0);    // dp_done on the last WAIT cycle wins
    run_key(8'd71, 0, 5'd8, 10, 1'b1);             // stall 10 with cfg pulses in OUT

    // Reset while in WAIT; a late dp_done must be ignored.
    bus.key_valid = 1'b1; bus.key_char = 8'd77;
    @(negedge clk);
    bus.key_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.dp_done = 1'b1; bus.dp_out = 5'd7;
    m_l = 0; m_m = 0; m_r = 0; m_err = 0;
    chk("wrst_pos", {pos_l, pos_m, pos_r}, 0);
    chk("wrst_outs", {bus.dp_start, bus.out_valid, error_flag, err_code, bus.key_ready}, 5'b00001);
    chk("wrst_data", {bus.dp_in, bus.out_char}, {5'd0, 8'd65});
    @(negedge clk);
    bus.dp_done = 1'b0;
    chk("wrst_ignore_done", {bus.out_valid, error_flag, bus.key_ready}, 3'b001);

    // Random keystrokes against the model.
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 5) == 0)
        load_cfg($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
      case ($urandom_range(0, 3))
        0: ch = 8'($urandom_range(0, 255));
        1: ch = 8'($urandom_range(97, 122));
        default: ch = 8'($urandom_range(65, 90));
      endcase
      lat = ($urandom_range(0, 7) == 0) ? $urandom_range(TIMEOUT - 1, TIMEOUT + 2)
                                        : $urandom_range(0, 4);
      case ($urandom_range(0, 7))
        0: res = is_letter(int'(ch)) ? 5'(letter_idx(int'(ch))) : 5'd0;
        1: res = 5'($urandom_range(26, 31));
        default: res = 5'($urandom_range(0, 25));
      endcase
      run_key(ch, lat, res, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enigma_key_sequencer.md
# enigma_key_sequencer

Control FSM between the keyboard front end and the Enigma cipher datapath. It accepts one ASCII keystroke at a time and validates it. For each valid letter it steps the rotor positions with the historical double-step rule, launches one datapath encipherment and checks the result. It then presents the ciphertext letter on a valid/ready output port. It also owns the rotor-position registers, which are loaded through a configuration port while idle.

## Interface
- NOTCH_R, 16 ('Q'): right-rotor turnover position; the middle rotor steps when the right rotor leaves it.
- NOTCH_M, 4 ('E'): middle-rotor turnover position; triggers the double step.
- TIMEOUT, 15: maximum number of WAIT cycles for dp_done before abort.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- key_valid  in  1  keystroke offered.
- key_char  in  8  ASCII keystroke.
- key_ready  out  1  high only in IDLE.
- cfg_we  in  1  load rotor positions; honoured only in IDLE with key_valid low.
- cfg_pos_l, cfg_pos_m, cfg_pos_r  in  5 each  new positions, 0..25.
- dp_start  out  1  one-cycle launch pulse to the datapath.
- dp_in  out  5  letter index 0..25; held stable from START until dp_done.
- pos_l, pos_m, pos_r  out  5 each  current rotor positions, registered.
- dp_done  in  1  datapath result valid; sampled only in WAIT.
- dp_out  in  5  datapath result index.
- out_valid  out  1  ciphertext available.
- out_char  out  8  uppercase ASCII ciphertext, 65..90.
- out_ready  in  1  consumer accepts.
- error_flag  out  1  one-cycle error pulse.
- err_code  out  2  0 none, 1 invalid key, 2 self-encipher, 3 timeout; held until the next error_flag.

## Operation
- States: IDLE, STEP, START, WAIT, OUT.
- IDLE:
  - Accept a key when key_valid and key_ready.
  - Inputs 65..90 give index = key_char-65. Inputs 97..122 give index = key_char-97.
  - If the key is valid, latch the index and go to STEP.
  - If the key is invalid, pulse error_flag with err_code=1 and stay in IDLE. The key is consumed and the rotors do not move.
- cfg_we in IDLE:
  - Loads pos_* from cfg_pos_* when key_valid is low.
  - A cfg value above 25 is reduced modulo 26 (v-26).
  - When cfg_we and key_valid are both high, the key wins and cfg is ignored.
  - cfg_we in any other state is ignored.
- STEP: compute all rotor updates from the old values, then go to START.
  - pos_r advances by one, wrapping 25 to 0.
  - pos_m advances if pos_r==NOTCH_R or pos_m==NOTCH_M.
  - pos_l advances if pos_m==NOTCH_M.
  - All increments wrap 25 to 0.
- START: drive dp_start=1 for exactly this cycle, then go to WAIT with the timeout counter cleared.
- WAIT: on dp_done, check dp_out.
  - If dp_out==latched index, pulse error_flag with err_code=2, discard the result and go to IDLE.
  - If dp_out>25, treat it the same way (err_code=2).
  - Otherwise register out_char=dp_out+65 and go to OUT.
  - If dp_done has not arrived after TIMEOUT cycles in WAIT, pulse error_flag with err_code=3 and go to IDLE.
  - The rotor step is kept after both abort cases.
- OUT: out_valid=1 with out_char held stable until out_ready. On the transfer cycle go to IDLE.

## Timing
- Reset values:
  - State is IDLE.
  - pos_l, pos_m and pos_r are 0.
  - dp_in is 0 and out_char is 65.
  - dp_start, out_valid and error_flag are 0.
  - err_code is 0 and key_ready is 1 in the cycle after reset.
- rst takes effect on the next edge from any state. An in-flight key is dropped, and any dp_done that arrives after reset is ignored.
- Key accepted at edge T:
  - STEP occupies T..T+1 and the new pos_* are visible after T+1.
  - dp_start is high in cycle T+2, and pos_* are already updated at that point.
  - The earliest dp_done is in cycle T+3, which gives out_valid in cycle T+4. Best-case latency from key to out_valid is 4 cycles.
- key_ready is low from STEP through OUT. Throughput is at most one key per 5 cycles.
- error_flag is never asserted together with out_valid.
- Timeout fires on the cycle where the WAIT count reaches TIMEOUT with dp_done still low. dp_done arriving in that same cycle wins.

## Test plan
- Reset, then key 'A' (65) with the datapath returning index 1 -> pos=(0,0,1), dp_start a single pulse at T+2, out_valid at T+4 with out_char 66, held until out_ready.
- Load cfg (0,3,16), then two keys -> first key gives pos (0,4,17); second key gives the double step, pos (1,5,18).
- Load cfg (0,0,25), then key 'z' (122) -> dp_in=25, pos (0,0,0); right-rotor wrap with no middle step.
- Key '@' (64) -> error_flag pulse, err_code=1, pos unchanged, key_ready stays 1, no dp_start.
- Key 'C' with the datapath returning index 2 -> err_code=2, no out_valid, back in IDLE, pos stepped. Then dp_done held low -> err_code=3 after 15 WAIT cycles.
- Stall out_ready for 10 cycles, and pulse cfg_we while in OUT -> out_char stable, pos unchanged by cfg. Assert rst while in WAIT -> every output returns to its reset value on the next cycle.
